// File: rtl/sbuf_pkg.sv
// rtl/sbuf_pkg.sv - shared types for the uncached store buffer
package sbuf_pkg;

  localparam int SBUF_ADDR_W = 32;
  localparam int SBUF_DATA_W = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic [SBUF_ADDR_W-1:0]   addr;
    logic [1:0]               size;
    logic [SBUF_DATA_W/8-1:0] wstrb;
    logic [SBUF_DATA_W-1:0]   wdata;
  } sbuf_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    W_WAIT = 2'd1,
    R_WAIT = 2'd2
  } sbuf_state_t;

endpackage

// File: rtl/sbuf_fifo.sv
// rtl/sbuf_fifo.sv - circular FIFO of posted store entries
module sbuf_fifo
  import sbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  sbuf_entry_t              push_entry_i,
  output sbuf_entry_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sbuf_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uncached_store_buffer.sv
// rtl/uncached_store_buffer.sv - posted-write buffer for uncached accesses
// Stores are acked at once and drained in order; loads pass only when empty.
module uncached_store_buffer
  import sbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SBUF_ADDR_W,
  parameter int DATA_W = SBUF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_req,
  input  logic                s_wr,
  input  logic [1:0]          s_size,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_wdata,
  output logic                s_addr_ok,
  output logic                s_data_ok,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [1:0]          m_size,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                sb_empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  sbuf_state_t      state_q, state_d;
  logic             store_ack_q, store_ack_d;
  sbuf_entry_t      push_entry, head;
  logic [CNT_W-1:0] count;
  logic             full, empty, pop;
  logic             store_acc, load_ok;

  assign push_entry = '{addr: s_addr, size: s_size, wstrb: s_wstrb, wdata: s_wdata};

  sbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (store_acc),
    .pop_i        (pop),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  // Store acceptance looks only at the registered count, so a full buffer
  // refuses even when the head retires in the same cycle.
  assign store_acc   = s_req & s_wr & ~full & (state_q != R_WAIT);
  // A pending store ack blocks loads so the two responses never collide.
  assign load_ok     = s_req & ~s_wr & empty & (state_q == IDLE) & ~store_ack_q;
  assign store_ack_d = store_acc;

  assign s_addr_ok = store_acc | (load_ok & m_addr_ok);
  assign s_data_ok = store_ack_q | ((state_q == R_WAIT) & m_data_ok);
  assign s_rdata   = ((state_q == R_WAIT) & m_data_ok) ? m_rdata : '0;
  assign sb_empty  = empty & (state_q == IDLE) & ~store_ack_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = '0;
    m_addr  = '0;
    m_wstrb = '0;
    m_wdata = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          m_req   = 1'b1;
          m_wr    = 1'b1;
          m_size  = head.size;
          m_addr  = head.addr;
          m_wstrb = head.wstrb;
          m_wdata = head.wdata;
          if (m_addr_ok) state_d = W_WAIT;
        end else if (load_ok) begin
          m_req  = 1'b1;
          m_size = s_size;
          m_addr = s_addr;
          if (m_addr_ok) state_d = R_WAIT;
        end
      end
      W_WAIT: begin
        if (m_data_ok) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      R_WAIT: begin
        if (m_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      store_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_ack_q <= store_ack_d;
    end
  end

  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
    !(m_data_ok && (state_q == IDLE)));
  a_full_matches_count: assert property (@(posedge clk) disable iff (reset)
    full == (count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_uncached_store_buffer.sv
// tb/tb_uncached_store_buffer.sv - directed scoreboard bench for uncached_store_buffer
module tb_uncached_store_buffer;
  import sbuf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        sb_empty;

  int n_cmp = 0;
  int n_mis = 0;
  sbuf_entry_t sb[$];

  uncached_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    s_req = 1'b1; s_wr = 1'b1; s_addr = a; s_size = SIZE_W; s_wstrb = strb; s_wdata = d;
    #1;
    chk("st_addr_ok", 64'(s_addr_ok), 64'd1);
    sb.push_back('{addr: a, size: SIZE_W, wstrb: strb, wdata: d});
    tick();
    s_req = 1'b0;
    #1;
    chk("st_data_ok", 64'(s_data_ok), 64'd1);
  endtask

  task automatic issue_one();
    sbuf_entry_t e;
    for (int i = 0; i < 20 && !(m_req === 1'b1 && m_wr === 1'b1); i++) tick();
    chk("issue_wr_req", 64'(m_req & m_wr), 64'd1);
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("m_addr",  64'(m_addr),  64'(e.addr));
      chk("m_size",  64'(m_size),  64'(e.size));
      chk("m_wstrb", 64'(m_wstrb), 64'(e.wstrb));
      chk("m_wdata", 64'(m_wdata), 64'(e.wdata));
    end
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    #1;
    chk("w_wait_no_req", 64'(m_req), 64'd0);
  endtask

  task automatic complete_one(input int lat);
    repeat (lat) tick();
    m_data_ok = 1'b1;
    #1;
    chk("w_resp_not_fwd", 64'(s_data_ok), 64'd0);
    tick();
    m_data_ok = 1'b0;
    #1;
  endtask

  task automatic drain_one(input int lat);
    issue_one();
    complete_one(lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; s_req = 0; s_wr = 0; s_size = 0; s_addr = 0; s_wstrb = 0; s_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    #2;
    chk("rst_sb_empty", 64'(sb_empty), 64'd1);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_s_data_ok", 64'(s_data_ok), 64'd0);
    chk("rst_s_addr_ok", 64'(s_addr_ok), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: single store
    do_store(32'h1FAF_0000, 32'hDEAD_BEEF, 4'hF);
    chk("t1_m_req", 64'(m_req), 64'd1);
    chk("t1_m_wr", 64'(m_wr), 64'd1);
    drain_one(1);
    chk("t1_sb_empty", 64'(sb_empty), 64'd1);

    // 2: fill, refuse fifth, drain in order, then fifth accepted
    for (int i = 0; i < 4; i++) do_store(32'h1FAF_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
    s_req = 1'b1; s_wr = 1'b1; s_addr = 32'h1FAF_1010; s_wdata = 32'hA000_0004;
    #1;
    chk("t2_full_refuse", 64'(s_addr_ok), 64'd0);
    tick();
    chk("t2_full_refuse2", 64'(s_addr_ok), 64'd0);
    s_req = 1'b0;
    for (int i = 0; i < 4; i++) drain_one(1);
    do_store(32'h1FAF_1010, 32'hA000_0004, 4'h3);
    drain_one(2);

    // 6: push coinciding with pop at count 3, pointer wrap checked by order
    for (int i = 0; i < 3; i++) do_store(32'h1FAF_2000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF);
    issue_one();
    s_req = 1'b1; s_wr = 1'b1; s_addr = 32'h1FAF_200C; s_size = SIZE_W; s_wstrb = 4'h1;
    s_wdata = 32'hB000_0003; m_data_ok = 1'b1;
    #1;
    chk("t6_push_pop_ok", 64'(s_addr_ok), 64'd1);
    sb.push_back('{addr: 32'h1FAF_200C, size: SIZE_W, wstrb: 4'h1, wdata: 32'hB000_0003});
    tick();
    s_req = 1'b0; m_data_ok = 1'b0;
    #1;
    chk("t6_ack", 64'(s_data_ok), 64'd1);
    do_store(32'h1FAF_2010, 32'hB000_0004, 4'hC);
    s_req = 1'b1; s_wr = 1'b1;
    #1;
    chk("t6_full_after", 64'(s_addr_ok), 64'd0);
    s_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) drain_one(1);
    chk("t6_sb_empty", 64'(sb_empty), 64'd1);

    // 3: load behind a store to the same address
    do_store(32'h1FAF_F020, 32'h0000_0011, 4'hF);
    s_req = 1'b1; s_wr = 1'b0; s_addr = 32'h1FAF_F020; s_size = SIZE_W;
    #1;
    chk("t3_load_stall", 64'(s_addr_ok), 64'd0);
    chk("t3_drain_first", 64'(m_wr), 64'd1);
    drain_one(1);
    chk("t3_ld_req", 64'(m_req), 64'd1);
    chk("t3_ld_wr", 64'(m_wr), 64'd0);
    chk("t3_ld_addr", 64'(m_addr), 64'h1FAF_F020);
    chk("t3_ld_wait_ok", 64'(s_addr_ok), 64'd0);
    m_addr_ok = 1'b1;
    #1;
    chk("t3_ld_addr_ok", 64'(s_addr_ok), 64'd1);
    tick();
    m_addr_ok = 1'b0; s_req = 1'b0;
    #1;
    chk("t3_r_wait_no_req", 64'(m_req), 64'd0);
    tick(); tick();
    m_data_ok = 1'b1; m_rdata = 32'h0000_00FF;
    #1;
    chk("t3_ld_data_ok", 64'(s_data_ok), 64'd1);
    chk("t3_ld_rdata", 64'(s_rdata), 64'h0000_00FF);
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("t3_data_ok_pulse", 64'(s_data_ok), 64'd0);
    chk("t3_sb_empty", 64'(sb_empty), 64'd1);

    // 4: store blocked while a load is outstanding
    s_req = 1'b1; s_wr = 1'b0; s_addr = 32'h1FAF_0100; m_addr_ok = 1'b1;
    #1;
    chk("t4_ld_accept", 64'(s_addr_ok), 64'd1);
    tick();
    m_addr_ok = 1'b0;
    s_wr = 1'b1; s_addr = 32'h1FAF_0200; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF; s_size = SIZE_W;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_st_blocked", 64'(s_addr_ok), 64'd0);
      tick();
    end
    m_data_ok = 1'b1; m_rdata = 32'hCAFE_0001;
    #1;
    chk("t4_ld_data_ok", 64'(s_data_ok), 64'd1);
    chk("t4_ld_rdata", 64'(s_rdata), 64'hCAFE_0001);
    chk("t4_st_still_blk", 64'(s_addr_ok), 64'd0);
    tick();
    m_data_ok = 1'b0;
    #1;
    chk("t4_st_accept", 64'(s_addr_ok), 64'd1);
    sb.push_back('{addr: 32'h1FAF_0200, size: SIZE_W, wstrb: 4'hF, wdata: 32'h5555_AAAA});
    tick();
    s_req = 1'b0;
    #1;
    chk("t4_st_ack", 64'(s_data_ok), 64'd1);
    drain_one(1);

    // 5: asynchronous reset while draining
    for (int i = 0; i < 3; i++) do_store(32'h1FAF_3000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF);
    issue_one();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_m_req", 64'(m_req), 64'd0);
    chk("t5_rst_data_ok", 64'(s_data_ok), 64'd0);
    chk("t5_rst_sb_empty", 64'(sb_empty), 64'd1);
    chk("t5_rst_m_addr", 64'(m_addr), 64'd0);
    sb.delete();
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("t5_no_stale_req", 64'(m_req), 64'd0);
    chk("t5_post_sb_empty", 64'(sb_empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
